// File: rtl/memrsp_pkg.sv
// Shared types and helpers for the data-memory responder.
package memrsp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } memrsp_state_t;

  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 2;

  // Word index wrapped to the array size; depth is a power of two.
  function automatic logic [WORD_W-OFFSET_W-1:0] addr_to_index(
    input logic [WORD_W-1:0] addr,
    input int unsigned       depth
  );
    return addr[WORD_W-1:OFFSET_W] & (WORD_W-OFFSET_W)'(depth - 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit storage: synchronous write, combinational read.
module dmem_array
  import memrsp_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: the storage has no reset on purpose; contents survive reset and
  // this keeps the array mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states on a valid/ready port.
// Define MEMRSP_ERR_EN to flag out-of-range word indices instead of wrapping.
module dmem_responder
  import memrsp_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = WORD_W - OFFSET_W;

  memrsp_state_t     state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [IW-1:0]     word_q;
  logic [WORD_W-1:0] wdata_q;

  logic              addr_err;
  logic              arr_we;
  logic [AW-1:0]     arr_addr;
  logic [WORD_W-1:0] arr_rdata;

`ifdef MEMRSP_ERR_EN
  assign addr_err = (word_q >= IW'(DEPTH));
`else
  assign addr_err = 1'b0;
`endif

  assign arr_addr = AW'(addr_to_index({word_q, {OFFSET_W{1'b0}}}, DEPTH));
  // A reset on the ACCESS edge wins, so the store is not committed.
  assign arr_we   = (state == ACCESS) && we_q && !addr_err && !reset;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            word_q  <= req_addr[WORD_W-1:OFFSET_W];
            wdata_q <= req_wdata;
            if (WAIT_STATES == 0) begin
              state <= ACCESS;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        ACCESS: begin
          rsp_rdata <= (we_q || addr_err) ? '0 : arr_rdata;
          rsp_err   <= addr_err;
          state     <= RESP;
        end
        RESP: begin
          // Valid rises on the first RESP edge; ready only counts once it is up.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: instance 0 has WAIT_STATES=0, instance 1 has WAIT_STATES=2.
module tb_dmem_responder;

`ifdef MEMRSP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.DEPTH(64), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One transaction on unit u; hold>0 keeps rsp_ready low that many cycles
  // after rsp_valid rises while a second request is pushed at the port.
  task automatic txn(input int u, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold, input int exp_lat,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int t;
    int lat;
    logic [31:0] rd;
    @(negedge clk);
    req_valid[u] = 1'b1;
    req_we[u]    = we;
    req_addr[u]  = addr;
    req_wdata[u] = wdata;
    rsp_ready[u] = (hold == 0);
    t = 0;
    while (!req_ready[u] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", 32'(req_ready[u]), 32'd1);
    @(posedge clk);
    #1;
    // Scramble the request bus; the latched copy must be used.
    req_valid[u] = 1'b0;
    req_we[u]    = ~we;
    req_addr[u]  = ~addr;
    req_wdata[u] = ~wdata;
    lat = 0;
    while (!rsp_valid[u] && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_rdata", rsp_rdata[u], exp_rdata);
    check("rsp_err", 32'(rsp_err[u]), 32'(exp_err));
    rd = rsp_rdata[u];
    if (hold > 0) begin
      req_valid[u] = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check("hold_valid", 32'(rsp_valid[u]), 32'd1);
        check("hold_rdata", rsp_rdata[u], rd);
        check("hold_req_ready", 32'(req_ready[u]), 32'd0);
      end
      req_valid[u] = 1'b0;
      rsp_ready[u] = 1'b1;
    end
    @(posedge clk);
    #1;
    check("rsp_valid_drop", 32'(rsp_valid[u]), 32'd0);
    check("back_idle", 32'(busy[u]), 32'd0);
    rsp_ready[u] = 1'b0;
  endtask

  typedef struct {
    int          u;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    int          lat;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs [11];

  initial begin
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = '0;
      req_wdata[u] = '0;   rsp_ready[u] = 1'b0;
    end

    //          u  we  addr         wdata         hold lat rdata                  err
    vecs[0]  = '{1, 1, 32'h64,  32'h7,        0, 4, 32'h0,                 1'b0};
    vecs[1]  = '{1, 0, 32'h64,  32'h0,        0, 4, 32'h7,                 1'b0};
    vecs[2]  = '{1, 0, 32'h67,  32'h0,        0, 4, 32'h7,                 1'b0};
    vecs[3]  = '{1, 1, 32'h60,  32'hA5A5_0F0F, 0, 4, 32'h0,                 1'b0};
    vecs[4]  = '{1, 0, 32'h60,  32'h0,        5, 4, 32'hA5A5_0F0F,         1'b0};
    vecs[5]  = '{0, 1, 32'h4,   32'hDEAD_BEEF, 0, 2, 32'h0,                 1'b0};
    vecs[6]  = '{0, 0, 32'h4,   32'h0,        0, 2, 32'hDEAD_BEEF,         1'b0};
    vecs[7]  = '{1, 1, 32'h0,   32'h11,       0, 4, 32'h0,                 1'b0};
    vecs[8]  = '{1, 1, 32'h100, 32'h55,       0, 4, 32'h0,                 ERR_EN};
    vecs[9]  = '{1, 0, 32'h0,   32'h0,        0, 4, ERR_EN ? 32'h11 : 32'h55, 1'b0};
    vecs[10] = '{1, 1, 32'h8,   32'h22,       0, 4, 32'h0,                 1'b0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("reset_req_ready", 32'(req_ready[u]), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid[u]), 32'd0);
      check("reset_rsp_rdata", rsp_rdata[u], 32'd0);
      check("reset_busy", 32'(busy[u]), 32'd0);
    end

    foreach (vecs[i])
      txn(vecs[i].u, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
          vecs[i].lat, vecs[i].rdata, vecs[i].err);

    // Out-of-range load: error flag with zero data, or wrap onto word 0.
    txn(1, 1'b0, 32'h100, 32'h0, 0, 4, ERR_EN ? 32'h0 : 32'h55, ERR_EN);

    // Reset during WAIT of a store to 0x8 must drop that store.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h8; req_wdata[1] = 32'h1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    check("wait_busy", 32'(busy[1]), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_reset_busy", 32'(busy[1]), 32'd0);
    check("mid_reset_req_ready", 32'(req_ready[1]), 32'd1);
    check("mid_reset_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("dropped_store_idle", 32'(busy[1]), 32'd0);
    txn(1, 1'b0, 32'h8, 32'h0, 0, 4, 32'h22, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
